// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one registered-read ROM port
// between two req/ack requesters, with a per-port read data holding register.
module rom_arbiter #(
   parameter int DW = 8,
   parameter int AW = 14
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          r0_req,
   input  logic [AW-1:0] r0_a,
   output logic          r0_ack,
   output logic [DW-1:0] r0_do,
   input  logic          r1_req,
   input  logic [AW-1:0] r1_a,
   output logic          r1_ack,
   output logic [DW-1:0] r1_do,
   output logic          rom_ce,
   output logic [AW-1:0] rom_a,
   input  logic [DW-1:0] rom_do,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, READ, CAPT} state_t;

   state_t state, state_nx;
   logic   gnt;      // granted port of the current transaction (0/1)
   logic   last;     // most recently granted port
   logic   grant;    // a grant is taken at this edge
   logic   gnt_nx;   // port chosen at this edge
   logic   elig0, elig1;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and grant decision; a port whose ack is high this cycle is
   // not eligible, so a req still held through its ack is not a new request
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      gnt_nx   = gnt;
      elig0    = r0_req & ~r0_ack;
      elig1    = r1_req & ~r1_ack;
      case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               state_nx = READ;
               grant    = 1'b1;
               if (elig0 & elig1) gnt_nx = ~last;
               else               gnt_nx = elig1;
            end
         end
         READ:    state_nx = CAPT;
         CAPT:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: ROM address/enable, grant history, data capture and ack pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         gnt    <= 1'b0;
         last   <= 1'b1;
         rom_ce <= 1'b0;
         rom_a  <= '0;
         r0_ack <= 1'b0;
         r1_ack <= 1'b0;
         r0_do  <= '0;
         r1_do  <= '0;
      end else begin
         r0_ack <= 1'b0;
         r1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  gnt    <= gnt_nx;
                  last   <= gnt_nx;
                  rom_a  <= gnt_nx ? r1_a : r0_a;
                  rom_ce <= 1'b1;
               end
            end
            READ: rom_ce <= 1'b0;
            CAPT: begin
               if (gnt) begin
                  r1_do  <= rom_do;
                  r1_ack <= 1'b1;
               end else begin
                  r0_do  <= rom_do;
                  r0_ack <= 1'b1;
               end
            end
            default: rom_ce <= 1'b0;
         endcase
      end
   end

   // Busy while a transaction is in READ or CAPT
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a
// behavioural registered-read ROM.
module tb_rom_arbiter;

   logic        clock;
   logic        reset;
   logic        r0_req, r1_req;
   logic [13:0] r0_a, r1_a;
   logic        r0_ack, r1_ack;
   logic [7:0]  r0_do, r1_do;
   logic        rom_ce;
   logic [13:0] rom_a;
   logic [7:0]  rom_do;
   logic        busy;

   int checks = 0;
   int errors = 0;

   rom_arbiter #(.DW(8), .AW(14)) dut (
      .clock  (clock),
      .reset  (reset),
      .r0_req (r0_req),
      .r0_a   (r0_a),
      .r0_ack (r0_ack),
      .r0_do  (r0_do),
      .r1_req (r1_req),
      .r1_a   (r1_a),
      .r1_ack (r1_ack),
      .r1_do  (r1_do),
      .rom_ce (rom_ce),
      .rom_a  (rom_a),
      .rom_do (rom_do),
      .busy   (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ROM contents
   function automatic logic [7:0] rom_fn(input logic [13:0] a);
      case (a)
         14'h0123: rom_fn = 8'hA5;
         14'h0010: rom_fn = 8'h11;
         14'h0020: rom_fn = 8'h22;
         14'h0100: rom_fn = 8'h3C;
         14'h0200: rom_fn = 8'hC3;
         default:  rom_fn = a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // Registered-read ROM, read on ce
   initial rom_do = 8'h00;
   always @(posedge clock) if (rom_ce) rom_do <= rom_fn(rom_a);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k0, k1;
      logic [7:0] ea;
      logic e0, e1;

      reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0; r0_a = '0; r1_a = '0;
      tick(); tick(); tick();
      chk("rst_r0_ack", 32'(r0_ack), 32'h0);
      chk("rst_r1_ack", 32'(r1_ack), 32'h0);
      chk("rst_r0_do",  32'(r0_do),  32'h0);
      chk("rst_r1_do",  32'(r1_do),  32'h0);
      chk("rst_rom_ce", 32'(rom_ce), 32'h0);
      chk("rst_rom_a",  32'(rom_a),  32'h0);
      chk("rst_busy",   32'(busy),   32'h0);
      reset = 1'b0;

      // Simultaneous requests after reset: port 0 first, port 1 at E3
      r0_req = 1'b1; r0_a = 14'h0010; r1_req = 1'b1; r1_a = 14'h0020;
      tick(); // E0
      chk("t2_e0_rom_a",  32'(rom_a),  32'h0010);
      chk("t2_e0_rom_ce", 32'(rom_ce), 32'h1);
      tick(); // E1
      tick(); // E2
      chk("t2_e2_r0_ack", 32'(r0_ack), 32'h1);
      chk("t2_e2_r0_do",  32'(r0_do),  32'h11);
      chk("t2_e2_r1_ack", 32'(r1_ack), 32'h0);
      r0_req = 1'b0;
      tick(); // E3
      chk("t2_e3_rom_ce", 32'(rom_ce), 32'h1);
      chk("t2_e3_rom_a",  32'(rom_a),  32'h0020);
      chk("t2_e3_r0_ack", 32'(r0_ack), 32'h0);
      tick(); // E4
      tick(); // E5
      chk("t2_e5_r1_ack", 32'(r1_ack), 32'h1);
      chk("t2_e5_r1_do",  32'(r1_do),  32'h22);
      chk("t2_e5_r0_do",  32'(r0_do),  32'h11);
      r1_req = 1'b0;
      tick();
      chk("t2_idle_rom_ce", 32'(rom_ce), 32'h0);

      // Single read on port 0
      r0_req = 1'b1; r0_a = 14'h0123;
      tick(); // E0
      chk("t1_e0_rom_ce", 32'(rom_ce), 32'h1);
      chk("t1_e0_rom_a",  32'(rom_a),  32'h0123);
      chk("t1_e0_busy",   32'(busy),   32'h1);
      tick(); // E1
      chk("t1_e1_rom_ce", 32'(rom_ce), 32'h0);
      chk("t1_e1_rom_a",  32'(rom_a),  32'h0123);
      chk("t1_e1_busy",   32'(busy),   32'h1);
      tick(); // E2
      chk("t1_e2_r0_ack", 32'(r0_ack), 32'h1);
      chk("t1_e2_r0_do",  32'(r0_do),  32'hA5);
      chk("t1_e2_r1_ack", 32'(r1_ack), 32'h0);
      chk("t1_e2_busy",   32'(busy),   32'h0);
      r0_req = 1'b0;
      tick(); // E3
      chk("t1_e3_r0_ack", 32'(r0_ack), 32'h0);
      chk("t1_e3_r0_do",  32'(r0_do),  32'hA5);

      // Held-req guard: req stays high through its ack
      r0_req = 1'b1; r0_a = 14'h0010;
      tick(); // E0
      chk("t4_e0_rom_ce", 32'(rom_ce), 32'h1);
      tick(); // E1
      tick(); // E2
      chk("t4_e2_r0_ack", 32'(r0_ack), 32'h1);
      chk("t4_e2_r0_do",  32'(r0_do),  32'h11);
      tick(); // E3: ack cycle, no grant
      chk("t4_e3_rom_ce", 32'(rom_ce), 32'h0);
      chk("t4_e3_busy",   32'(busy),   32'h0);
      chk("t4_e3_r0_ack", 32'(r0_ack), 32'h0);
      r0_a = 14'h0020;
      tick(); // E4: new grant
      chk("t4_e4_rom_ce", 32'(rom_ce), 32'h1);
      chk("t4_e4_rom_a",  32'(rom_a),  32'h0020);
      chk("t4_e4_r0_do",  32'(r0_do),  32'h11);
      tick(); // E5
      chk("t4_e5_r0_do",  32'(r0_do),  32'h11);
      tick(); // E6
      chk("t4_e6_r0_ack", 32'(r0_ack), 32'h1);
      chk("t4_e6_r0_do",  32'(r0_do),  32'h22);
      r0_req = 1'b0;
      tick();

      // Address change after grant is ignored
      r1_req = 1'b1; r1_a = 14'h0100;
      tick(); // grant
      chk("t5_e0_rom_a", 32'(rom_a), 32'h0100);
      r1_a = 14'h0200;
      tick();
      chk("t5_e1_rom_a", 32'(rom_a), 32'h0100);
      tick();
      chk("t5_e2_r1_ack", 32'(r1_ack), 32'h1);
      chk("t5_e2_r1_do",  32'(r1_do),  32'h3C);
      chk("t5_e2_r0_do",  32'(r0_do),  32'h22);
      r1_req = 1'b0;
      tick();

      // Continuous contention: last grant was port 1, so port 0 leads
      k0 = 0; k1 = 0;
      r0_req = 1'b1; r0_a = 14'h0030; r1_req = 1'b1; r1_a = 14'h0040;
      for (int i = 1; i <= 18; i++) begin
         tick();
         e0 = (i % 3 == 0) && ((i / 3) % 2 == 1);
         e1 = (i % 3 == 0) && ((i / 3) % 2 == 0);
         chk($sformatf("t3_c%0d_r0_ack", i), 32'(r0_ack), 32'(e0));
         chk($sformatf("t3_c%0d_r1_ack", i), 32'(r1_ack), 32'(e1));
         if (e0 && r0_ack) begin
            ea = (8'h30 + 8'(k0)) ^ 8'h5A;
            chk($sformatf("t3_c%0d_r0_do", i), 32'(r0_do), 32'(ea));
            k0++;
            r0_a = 14'h0030 + 14'(k0);
         end
         if (e1 && r1_ack) begin
            ea = (8'h40 + 8'(k1)) ^ 8'h5A;
            chk($sformatf("t3_c%0d_r1_do", i), 32'(r1_do), 32'(ea));
            k1++;
            r1_a = 14'h0040 + 14'(k1);
         end
      end
      chk("t3_acks_total", 32'(k0 + k1), 32'd6);
      r0_req = 1'b0; r1_req = 1'b0;
      tick();
      chk("t3_end_rom_ce", 32'(rom_ce), 32'h0);

      // Reset during READ aborts the read
      r0_req = 1'b1; r0_a = 14'h0010;
      tick(); // grant, now in READ
      chk("t6_e0_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      tick();
      chk("t6_rst_rom_ce", 32'(rom_ce), 32'h0);
      chk("t6_rst_busy",   32'(busy),   32'h0);
      chk("t6_rst_r0_do",  32'(r0_do),  32'h0);
      chk("t6_rst_r1_do",  32'(r1_do),  32'h0);
      chk("t6_rst_r0_ack", 32'(r0_ack), 32'h0);
      reset = 1'b0;
      r1_req = 1'b1; r1_a = 14'h0020;
      tick(); // tie after reset -> port 0
      chk("t6_e0_rom_a",  32'(rom_a),  32'h0010);
      chk("t6_e0_r0_ack", 32'(r0_ack), 32'h0);
      tick();
      tick();
      chk("t6_e2_r0_ack", 32'(r0_ack), 32'h1);
      chk("t6_e2_r0_do",  32'(r0_do),  32'h11);
      chk("t6_e2_r1_ack", 32'(r1_ack), 32'h0);
      r0_req = 1'b0; r1_req = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
